hier_node_rr_mux: RTL and testbench

//  Parametrised hierarchy node: merges NUM_CH child valid/ready streams into one parent stream.

---
 rtl/hier_node_pkg.sv | 43 ++++
 rtl/hier_node_rr_mux_if.sv | 36 +++
 rtl/hier_node_rr_arb.sv | 46 ++++
 rtl/hier_node_rr_mux.sv | 129 ++++++++++++
 tb/tb_hier_node_rr_mux.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hier_node_pkg.sv
// -----------------------------------------------------------------------------
// hier_node_pkg
// Shared definitions for the hierarchy-node round-robin mux:
//   NUM_CH_MAX  - largest supported channel count (index width IDX_W)
//   rr_pick_t   - result of a round-robin search (found bit + channel index)
//   rr_first()  - first set request at or after a pointer, wrapping at num_ch
//   lock_state_e- packet-lock FSM states (used only with HIER_NODE_PKT_LOCK_EN)
// -----------------------------------------------------------------------------
package hier_node_pkg;

  localparam int NUM_CH_MAX = 64;
  localparam int IDX_W      = $clog2(NUM_CH_MAX);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;

  // Search order is ptr, ptr+1, ... with an explicit subtract-wrap at num_ch,
  // so channel counts that are not a power of two never alias by truncation.
  function automatic rr_pick_t rr_first(input logic [NUM_CH_MAX-1:0] valid,
                                        input logic [IDX_W-1:0]      ptr,
                                        input int                    num_ch);
    rr_pick_t pick;
    int       c;
    pick = '0;
    for (int i = 0; i < NUM_CH_MAX; i++) begin
      c = int'(ptr) + i;
      if (c >= num_ch) c = c - num_ch;
      if ((i < num_ch) && !pick.found && valid[c]) begin
        pick.found = 1'b1;
        pick.idx   = IDX_W'(c);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hier_node_rr_mux_if.sv
// -----------------------------------------------------------------------------
// hier_node_rr_mux_if
// Bundles the child-side streams and the parent-side stream of one node.
//   in_valid/in_ready/in_data/in_last : NUM_CH child streams (data packed
//                                       channel c at [c*DATA_W +: DATA_W])
//   out_valid/out_ready/out_data/out_id/out_last : merged parent stream
//   busy : node holds a beat or any child is requesting
// modport master : the node itself (drives in_ready and the parent stream)
// modport slave  : the surroundings (children + parent)
// -----------------------------------------------------------------------------
interface hier_node_rr_mux_if #(
  parameter int NUM_CH = 15,
  parameter int DATA_W = 32,
  parameter int ID_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [ID_W-1:0]          out_id;
  logic                     out_last;
  logic                     busy;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_id, out_last, busy
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_id, out_last, busy
  );
endinterface

// File: rtl/hier_node_rr_arb.sv
// -----------------------------------------------------------------------------
// hier_node_rr_arb
// Round-robin picker plus its pointer register.
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-channel requests
//   advance   : move the pointer past the current grant this cycle
//   gnt_idx   : granted channel (valid when gnt_vld)
//   gnt_vld   : at least one request present
// -----------------------------------------------------------------------------
module hier_node_rr_arb
  import hier_node_pkg::*;
#(
  parameter int NUM_CH = 15,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [ID_W-1:0]   gnt_idx,
  output logic              gnt_vld
);

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  rr_pick_t        pick;

  // NOTE: every variable gets a default before any condition; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    pick     = rr_first(NUM_CH_MAX'(req), IDX_W'(rr_ptr_q), NUM_CH);
    gnt_idx  = ID_W'(pick.idx);
    gnt_vld  = pick.found;
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = (pick.idx == IDX_W'(NUM_CH - 1)) ? '0 : ID_W'(pick.idx + IDX_W'(1));
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/hier_node_rr_mux.sv
// -----------------------------------------------------------------------------
// hier_node_rr_mux
// Merges NUM_CH child valid/ready streams into one registered parent stream,
// round-robin arbitrated, each beat tagged with its source channel id.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : hier_node_rr_mux_if.master (child streams in, parent stream out)
// Optional build macro HIER_NODE_PKT_LOCK_EN: once a channel sends a beat with
// in_last=0 the grant stays on that channel until its in_last=1 beat.
// -----------------------------------------------------------------------------
module hier_node_rr_mux
  import hier_node_pkg::*;
#(
  parameter int NUM_CH = 15,
  parameter int DATA_W = 32,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input logic                clk,
  input logic                rst,
  hier_node_rr_mux_if.master bus
);

  // Declared here because its field widths follow this module's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              last;
  } hier_beat_t;

  hier_beat_t        beat_q, beat_d;
  logic              out_valid_q, out_valid_d;
  logic              load_en, xfer, advance, gnt_vld, sel_last;
  logic [ID_W-1:0]   gnt_idx;
  logic [NUM_CH-1:0] req, gnt_oh;
  logic [DATA_W-1:0] slot [NUM_CH];
  logic [DATA_W-1:0] sel_data;

  // Output register may take a new beat when empty or being drained.
  assign load_en = ~out_valid_q | bus.out_ready;
  assign xfer    = ~rst & load_en & gnt_vld;
  assign gnt_oh  = NUM_CH'(1) << gnt_idx;

  hier_node_rr_arb #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // One-hot AND-OR payload select.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    assign slot[c] = bus.in_data[c*DATA_W +: DATA_W] & {DATA_W{gnt_oh[c]}};
  end

  always_comb begin
    sel_data = '0;
    for (int c = 0; c < NUM_CH; c++) sel_data |= slot[c];
  end

  assign sel_last = |(bus.in_last & gnt_oh);

`ifdef HIER_NODE_PKT_LOCK_EN
  lock_state_e     state_q, state_d;
  logic [ID_W-1:0] lock_ch_q, lock_ch_d;

  // While locked only the owning channel is visible to the arbiter; the
  // pointer moves only when a packet ends.
  assign req     = (state_q == LOCKED) ? (bus.in_valid & (NUM_CH'(1) << lock_ch_q))
                                       : bus.in_valid;
  assign advance = xfer & sel_last;

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      IDLE: begin
        if (xfer && !sel_last) begin
          state_d   = LOCKED;
          lock_ch_d = gnt_idx;
        end
      end
      LOCKED: begin
        if (xfer && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`else
  assign req     = bus.in_valid;
  assign advance = xfer;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    if (load_en) out_valid_d = xfer;
    if (xfer)    beat_d = '{data: sel_data, id: gnt_idx, last: sel_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
    end
  end

  assign bus.in_ready  = gnt_oh & {NUM_CH{xfer}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = beat_q.data;
  assign bus.out_id    = beat_q.id;
  assign bus.out_last  = beat_q.last;
  assign bus.busy      = out_valid_q | (|bus.in_valid);

endmodule

// File: tb/tb_hier_node_rr_mux.sv
// -----------------------------------------------------------------------------
// tb_hier_node_rr_mux
// Drives a 15-channel and a 5-channel node in lockstep and compares them every
// cycle with a queue-free behavioural model (arbitration by modulo search).
// Directed steps cover reset, full round-robin sweep, single channel, output
// hold, wrap, packet behaviour and mid-run reset; a random phase follows.
// -----------------------------------------------------------------------------
module tb_hier_node_rr_mux;

  localparam int DW     = 32;
  localparam int DW_ALL = 64 * 32;
`ifdef HIER_NODE_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    bit          ov;
    logic [31:0] od;
    int          oid;
    bit          ol;
    int          ptr;
    bit          lock;
    int          lch;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hier_node_rr_mux_if #(.NUM_CH(15), .DATA_W(DW), .ID_W(4)) bus15 ();
  hier_node_rr_mux_if #(.NUM_CH(5),  .DATA_W(DW), .ID_W(3)) bus5 ();

  hier_node_rr_mux #(.NUM_CH(15), .DATA_W(DW), .ID_W(4)) u_dut15 (
    .clk (clk), .rst (rst), .bus (bus15)
  );
  hier_node_rr_mux #(.NUM_CH(5), .DATA_W(DW), .ID_W(3)) u_dut5 (
    .clk (clk), .rst (rst), .bus (bus5)
  );

  int   total = 0;
  int   bad   = 0;
  mdl_t m15, m5;

  function automatic mdl_t mreset();
    mdl_t m;
    m.ov = 0; m.od = '0; m.oid = 0; m.ol = 0; m.ptr = 0; m.lock = 0; m.lch = 0;
    return m;
  endfunction

  // Channel the rules say should win, or -1.
  function automatic int mpick(mdl_t m, int n, logic [63:0] v);
    if (LOCK_EN && m.lock) return v[m.lch] ? m.lch : -1;
    for (int i = 0; i < n; i++) begin
      int c;
      c = (m.ptr + i) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [63:0] mready(mdl_t m, int n, logic [63:0] v, bit ordy, bit r);
    logic [63:0] res;
    int          g;
    res = '0;
    if (!r && (!m.ov || ordy)) begin
      g = mpick(m, n, v);
      if (g >= 0) res[g] = 1'b1;
    end
    return res;
  endfunction

  function automatic mdl_t mnext(mdl_t m, int n, logic [63:0] v, logic [DW_ALL-1:0] d,
                                 logic [63:0] l, bit ordy, bit r);
    mdl_t x;
    int   g;
    x = m;
    if (r) return mreset();
    if (m.ov && !ordy) return x;
    g = mpick(m, n, v);
    if (g < 0) begin
      x.ov = 0;
      return x;
    end
    x.ov  = 1;
    x.od  = d[g*32 +: 32];
    x.oid = g;
    x.ol  = l[g];
    if (LOCK_EN && !l[g]) begin
      x.lock = 1;
      x.lch  = g;
    end else begin
      x.lock = 0;
      x.ptr  = (g + 1) % n;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already applied; check both nodes, clock once, advance models.
  task automatic cycle();
    logic [63:0] er15, er5;
    #2;
    er15 = mready(m15, 15, 64'(bus15.in_valid), bus15.out_ready, rst);
    er5  = mready(m5,  5,  64'(bus5.in_valid),  bus5.out_ready,  rst);
    check("out_valid15", 64'(bus15.out_valid), 64'(m15.ov));
    if (m15.ov) begin
      check("out_data15", 64'(bus15.out_data), 64'(m15.od));
      check("out_id15",   64'(bus15.out_id),   64'(m15.oid));
      check("out_last15", 64'(bus15.out_last), 64'(m15.ol));
    end
    check("in_ready15", 64'(bus15.in_ready), er15);
    check("busy15", 64'(bus15.busy), 64'(m15.ov | (|bus15.in_valid)));
    check("out_valid5", 64'(bus5.out_valid), 64'(m5.ov));
    if (m5.ov) begin
      check("out_data5", 64'(bus5.out_data), 64'(m5.od));
      check("out_id5",   64'(bus5.out_id),   64'(m5.oid));
      check("out_last5", 64'(bus5.out_last), 64'(m5.ol));
    end
    check("in_ready5", 64'(bus5.in_ready), er5);
    check("busy5", 64'(bus5.busy), 64'(m5.ov | (|bus5.in_valid)));
    @(posedge clk);
    m15 = mnext(m15, 15, 64'(bus15.in_valid), DW_ALL'(bus15.in_data), 64'(bus15.in_last),
                bus15.out_ready, rst);
    m5  = mnext(m5, 5, 64'(bus5.in_valid), DW_ALL'(bus5.in_data), 64'(bus5.in_last),
                bus5.out_ready, rst);
    #1;
  endtask

  task automatic rand_data15();
    for (int c = 0; c < 15; c++) bus15.in_data[c*DW +: DW] = $urandom;
  endtask

  task automatic rand_data5();
    for (int c = 0; c < 5; c++) bus5.in_data[c*DW +: DW] = $urandom;
  endtask

  task automatic idle5();
    bus5.in_valid  = '0;
    bus5.in_last   = '1;
    bus5.out_ready = 1'b1;
  endtask

  initial begin
    logic [63:0] er;
    int          b2;
    int          got[$];
    int          exp_pkt[6];

    bus15.in_valid = '0; bus15.in_last = '1; bus15.in_data = '0; bus15.out_ready = 1'b1;
    bus5.in_data = '0;
    idle5();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m15 = mreset();
    m5  = mreset();

    // Reset: outputs cleared, no ready while reset held even with requests.
    bus15.in_valid = '1;
    cycle();
    check("rst_out_data", 64'(bus15.out_data), 64'h0);
    check("rst_out_id",   64'(bus15.out_id),   64'h0);
    check("rst_out_last", 64'(bus15.out_last), 64'h0);
    rst = 1'b0;

    // Full sweep: every channel valid, ids rotate 0..14 twice.
    bus15.in_valid = '1;
    bus15.out_ready = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      bus15.in_last = 15'($urandom);
      rand_data15();
      cycle();
      check("sweep_valid", 64'(bus15.out_valid), 64'h1);
      check("sweep_id",    64'(bus15.out_id),    64'((k - 1) % 15));
    end

    // Single channel 7, then pointer must sit at 8.
    bus15.in_valid = 15'(1 << 7);
    bus15.in_data[7*DW +: DW] = 32'hA5A5_0007;
    cycle();
    check("ch7_data", 64'(bus15.out_data), 64'hA5A5_0007);
    check("ch7_id",   64'(bus15.out_id),   64'h7);
    bus15.in_valid = 15'((1 << 6) | (1 << 8));
    cycle();
    check("after7_id", 64'(bus15.out_id), 64'h8);

    // Hold: parent stalls for 5 cycles while inputs churn.
    bus15.in_valid  = '1;
    bus15.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_data15();
      #2;
      check("hold_ready", 64'(bus15.in_ready), 64'h0);
      cycle();
      check("hold_id", 64'(bus15.out_id), 64'h8);
    end
    bus15.out_ready = 1'b1;
    cycle();
    check("release_valid", 64'(bus15.out_valid), 64'h1);
    check("release_id",    64'(bus15.out_id),    64'h9);

    // Wrap: 15-ch ptr=4 with {3,14}; 5-ch ptr=4 with {1,4}.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus15.in_valid = 15'(1 << 3);
    bus5.in_valid  = 5'(1 << 3);
    cycle();
    bus15.in_valid = 15'((1 << 3) | (1 << 14));
    bus5.in_valid  = 5'((1 << 1) | (1 << 4));
    rand_data5();
    cycle();
    check("wrap15_first", 64'(bus15.out_id), 64'd14);
    check("wrap5_first",  64'(bus5.out_id),  64'd4);
    cycle();
    check("wrap15_second", 64'(bus15.out_id), 64'd3);
    check("wrap5_second",  64'(bus5.out_id),  64'd1);
    idle5();

    // Packet: ch 2 sends 4 beats (last on 4th); ch 1 joins one cycle later.
    rst = 1'b1;
    bus15.in_valid = '0;
    cycle();
    rst = 1'b0;
    b2 = 0;
    for (int k = 0; k < 10; k++) begin
      logic [14:0] v;
      v = '0;
      if (b2 < 4) begin
        v[2] = 1'b1;
        bus15.in_data[2*DW +: DW] = 32'h2000_0000 + 32'(b2);
        bus15.in_last[2] = (b2 == 3);
      end
      if (k >= 1) begin
        v[1] = 1'b1;
        bus15.in_data[1*DW +: DW] = 32'h1000_0000 + 32'(k);
        bus15.in_last[1] = 1'b1;
      end
      bus15.in_valid = v;
      er = mready(m15, 15, 64'(v), bus15.out_ready, rst);
      if (er[2]) b2++;
      cycle();
      if (bus15.out_valid) got.push_back(int'(bus15.out_id));
    end
    if (LOCK_EN) exp_pkt = '{2, 2, 2, 2, 1, 1};
    else         exp_pkt = '{2, 1, 2, 1, 2, 1};
    check("pkt_beats", 64'(got.size() >= 6), 64'h1);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check("pkt_order", 64'(got[i]), 64'(exp_pkt[i]));
    end

    // Reset while a beat is held: beat discarded, lowest valid wins after.
    bus15.in_valid = 15'(1 << 10);
    bus15.in_last  = '1;
    cycle();
    check("pre_rst_valid", 64'(bus15.out_valid), 64'h1);
    rst = 1'b1;
    cycle();
    check("post_rst_valid", 64'(bus15.out_valid), 64'h0);
    rst = 1'b0;
    bus15.in_valid = 15'((1 << 9) | (1 << 5));
    cycle();
    check("post_rst_id", 64'(bus15.out_id), 64'd5);

    // Random phase, occasional reset, dropping valids and parent stalls.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus15.in_valid  = 15'($urandom);
      bus15.in_last   = 15'($urandom);
      bus15.out_ready = ($urandom_range(0, 3) != 0);
      bus5.in_valid   = 5'($urandom);
      bus5.in_last    = 5'($urandom);
      bus5.out_ready  = ($urandom_range(0, 3) != 0);
      rand_data15();
      rand_data5();
      cycle();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
